seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Parametrised multiplexed 7-segment scan controller for Nexys4DDR displays.
//  Drives 1..8 common-anode digits from a packed hex word, with:
//   - per-digit decimal point, per-digit enable, optional leading-zero blanking;
//   - a built-in refresh divider and an inter-digit blanking (anti-ghost) gap;
//   - tear-free updates: new data is loaded only at a frame boundary.
//  Sits between user logic (switches/counters) and the C/DP/AN board pins.
// PARAMETERS
//  NUM_DIGITS  8      digits scanned, 1..8; AN width
//  TICK_DIV    25000  clk cycles per digit slot (100 MHz -> 250 us/slot); >=4
//  BLANK_CYC   200    cycles of each slot with all anodes off; < TICK_DIV
// PORTS
//  clk       in   1             system clock, 100 MHz
//  rst       in   1             asynchronous reset, active-low
//  en        in   1             1 = scan; 0 = all digits dark, scan frozen
//  load      in   1             1-cycle strobe: capture value/dp_in/dig_en/lz_sup
//  value     in   4*NUM_DIGITS  hex nibbles; [3:0] = digit 0 (rightmost)
//  dp_in     in   NUM_DIGITS    decimal point per digit, 1 = lit
//  dig_en    in   NUM_DIGITS    digit enable, 0 = digit always dark
//  lz_sup    in   1             1 = blank leading zero digits
//  c         out  7             segments g..a, active-low
//  dp        out  1             decimal point, active-low
//  an        out  NUM_DIGITS    anodes, active-low, one-hot-low when driving
//  frame_done out 1             1-cycle pulse when the last digit slot ends
// BEHAVIOUR
//  Reset (rst=0, async): c=7'h7F, dp=1, an=all 1s, frame_done=0, tick=0,
//   digit index=0, state=IDLE, shadow regs=0, pending flag=0.
//  Shadow/pending: load sets pending and stores inputs in a staging register.
//   A later load before the frame boundary overwrites the staging register.
//   At frame boundary (index wraps NUM_DIGITS-1 -> 0), or in IDLE,
//   staging->shadow and pending clears. Display uses only shadow regs.
//  Tick counter: 0..TICK_DIV-1, wraps; slot ends when tick==TICK_DIV-1.
//  FSM:
//   IDLE : outputs dark. If en=1, go BLANK with index=0, tick=0.
//   BLANK: an all 1s, c=7'h7F, dp=1 while tick<BLANK_CYC, then DRIVE.
//   DRIVE: an[index]=0, others 1.
//          c = decode(shadow nibble[index]) using table 0..F:
//           0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
//           8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
//          dp = ~shadow_dp[index].
//          On slot end: index++, wrapping at NUM_DIGITS-1; go BLANK.
//          frame_done=1 for that cycle iff index was NUM_DIGITS-1.
//   en=0 in any state: next cycle IDLE, outputs dark, tick/index cleared.
//  Suppression: a digit is dark (an stays 1 for its slot; slot time preserved)
//   if dig_en[i]=0.
//   If lz_sup=1, a digit is also dark when it and all higher-indexed digits
//   are 0. Digit 0 is never suppressed by lz_sup. dp of a suppressed digit is
//   not driven.
//  Outputs are registered: an/c/dp change on the same edge (no
//   segment/anode skew); latency from slot start to pins is 1 clk.
//  NUM_DIGITS=1: index stays 0; frame_done pulses every slot.
//  rst during DRIVE: outputs dark immediately (async); staging and pending
//   data are discarded.
// TESTING
//  1 Reset: hold rst=0 mid-DRIVE -> an=FF, c=7F, dp=1 immediately;
//    release -> IDLE.
//  2 Scan: N=4, TICK_DIV=8, BLANK_CYC=2, load value=16'h12AF, en=1 ->
//    an cycles E,D,B,7; c=0E,08,24,79; each slot = 2 dark + 6 lit cycles.
//  3 Tear-free: load 16'h1111, then 16'h2222 mid-frame -> current frame shows
//    1s only; next frame shows 2s; frame_done pulses once per frame.
//  4 Leading zeros: value=16'h0050, lz_sup=1 -> digits 3,2 dark; digits 1,0
//    show 5,0. value=0 -> only digit 0 lit with 0 (c=40).
//  5 Masks/dp: dig_en=4'b0101, dp_in=4'b0001 -> only an[0]/an[2] go low;
//    dp=0 only in digit-0 slot.
//  6 en toggle: drop en mid-slot -> dark next cycle; raise en -> restart at
//    digit 0 with full BLANK gap.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller for common-anode displays.
// Scans NUM_DIGITS digits from a packed hex word and inserts a dark gap at the
// start of every digit slot to avoid ghosting. New data is staged and only
// applied at a frame boundary, so a frame never shows a mix of old and new data.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 25000,
  parameter int BLANK_CYC  = 200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    lz_sup,
  output logic [6:0]              c,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0]     BLANK_T   = TICK_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, DRIVE = 2'd2} state_t;

  state_t                  state_reg, state_next;
  logic [TICK_W-1:0]       tick_reg, tick_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;

  // Staging (written by load) and shadow (used by the display) copies
  logic [4*NUM_DIGITS-1:0] stg_val_reg, shd_val_reg;
  logic [NUM_DIGITS-1:0]   stg_dp_reg, shd_dp_reg;
  logic [NUM_DIGITS-1:0]   stg_en_reg, shd_en_reg;
  logic                    stg_lz_reg, shd_lz_reg;
  logic                    pend_reg;

  logic [6:0]              c_reg, c_next;
  logic                    dp_reg, dp_next;
  logic [NUM_DIGITS-1:0]   an_reg, an_next;
  logic                    fd_reg, fd_next;

  logic                    slot_end;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   vis;
  logic [3:0]              nib [NUM_DIGITS];

  genvar gi;

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nib[gi] = shd_val_reg[4*gi +: 4];
    end
  endgenerate

  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    case (h)
      4'h0:    seg_decode = 7'h40;
      4'h1:    seg_decode = 7'h79;
      4'h2:    seg_decode = 7'h24;
      4'h3:    seg_decode = 7'h30;
      4'h4:    seg_decode = 7'h19;
      4'h5:    seg_decode = 7'h12;
      4'h6:    seg_decode = 7'h02;
      4'h7:    seg_decode = 7'h78;
      4'h8:    seg_decode = 7'h00;
      4'h9:    seg_decode = 7'h10;
      4'hA:    seg_decode = 7'h08;
      4'hB:    seg_decode = 7'h03;
      4'hC:    seg_decode = 7'h46;
      4'hD:    seg_decode = 7'h21;
      4'hE:    seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  // Per-digit visibility: masked digits and (optionally) leading zeros stay dark
  always_comb begin
    zero_run = 1'b1;
    vis      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (nib[i] == 4'h0);
      vis[i]   = shd_en_reg[i] & ~(shd_lz_reg & (i != 0) & zero_run);
    end
  end

  // State, slot timer and digit index registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      tick_reg  <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      idx_reg   <= idx_next;
    end
  end

  // Next-state logic and the pin values to be registered on this edge
  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    idx_next   = idx_reg;
    slot_end   = (tick_reg == TICK_LAST);
    an_next    = AN_OFF;
    c_next     = 7'h7F;
    dp_next    = 1'b1;
    fd_next    = 1'b0;

    if (!en) begin
      state_next = IDLE;
      tick_next  = '0;
      idx_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = (BLANK_T != '0) ? BLANK : DRIVE;
          tick_next  = '0;
          idx_next   = '0;
        end
        BLANK: begin
          tick_next = tick_reg + TICK_W'(1);
          if (tick_reg == BLANK_T - TICK_W'(1)) state_next = DRIVE;
        end
        DRIVE: begin
          if (vis[idx_reg]) begin
            an_next = AN_OFF & ~(NUM_DIGITS'(1) << idx_reg);
            c_next  = seg_decode(nib[idx_reg]);
            dp_next = ~shd_dp_reg[idx_reg];
          end
          if (slot_end) begin
            tick_next  = '0;
            idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
            state_next = (BLANK_T != '0) ? BLANK : DRIVE;
            fd_next    = (idx_reg == IDX_LAST);
          end else begin
            tick_next = tick_reg + TICK_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          tick_next  = '0;
          idx_next   = '0;
        end
      endcase
    end
  end

  // Registered pins so anodes and segments switch on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_reg <= AN_OFF;
      c_reg  <= 7'h7F;
      dp_reg <= 1'b1;
      fd_reg <= 1'b0;
    end else begin
      an_reg <= an_next;
      c_reg  <= c_next;
      dp_reg <= dp_next;
      fd_reg <= fd_next;
    end
  end

  // Capture loads into staging; promote to shadow at a frame boundary or while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_val_reg <= '0;
      stg_dp_reg  <= '0;
      stg_en_reg  <= '0;
      stg_lz_reg  <= 1'b0;
      shd_val_reg <= '0;
      shd_dp_reg  <= '0;
      shd_en_reg  <= '0;
      shd_lz_reg  <= 1'b0;
      pend_reg    <= 1'b0;
    end else begin
      if (load) begin
        stg_val_reg <= value;
        stg_dp_reg  <= dp_in;
        stg_en_reg  <= dig_en;
        stg_lz_reg  <= lz_sup;
      end
      if (state_reg == IDLE) begin
        // Nothing is on the pins, so a load can take effect directly
        if (load) begin
          shd_val_reg <= value;
          shd_dp_reg  <= dp_in;
          shd_en_reg  <= dig_en;
          shd_lz_reg  <= lz_sup;
        end else if (pend_reg) begin
          shd_val_reg <= stg_val_reg;
          shd_dp_reg  <= stg_dp_reg;
          shd_en_reg  <= stg_en_reg;
          shd_lz_reg  <= stg_lz_reg;
        end
        pend_reg <= 1'b0;
      end else if (fd_next) begin
        if (pend_reg) begin
          shd_val_reg <= stg_val_reg;
          shd_dp_reg  <= stg_dp_reg;
          shd_en_reg  <= stg_en_reg;
          shd_lz_reg  <= stg_lz_reg;
        end
        // A load coinciding with the boundary waits for the next frame
        pend_reg <= load;
      end else if (load) begin
        pend_reg <= 1'b1;
      end
    end
  end

  assign an         = an_reg;
  assign c          = c_reg;
  assign dp         = dp_reg;
  assign frame_done = fd_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a time-based reference model predicts the pins for
// every clock, a monitor compares the DUT against the queued predictions.
module tb_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int TD = 8;
  localparam int BC = 2;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dpm;
    logic [3:0]  enm;
    logic        lz;
  } disp_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] c;
    logic       dp;
    logic       fd;
  } pins_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  dig_en;
  logic        lz_sup;
  logic [6:0]  c;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  logic [6:0]  seg_tab [16];
  pins_t       exp_q [$];
  pins_t       last_exp;
  int          n_pass;
  int          n_total;
  int          cyc;

  // Reference model state: scanning flag, cycles since scan start, data copies
  bit          m_act;
  int          m_t;
  disp_t       m_shd;
  disp_t       m_stg;
  bit          m_pend;

  seg_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(TD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
    .dp_in(dp_in), .dig_en(dig_en), .lz_sup(lz_sup),
    .c(c), .dp(dp), .an(an), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic disp_t mk(input logic [15:0] v, input logic [3:0] d,
                               input logic [3:0] m, input logic z);
    disp_t r;
    r.val = v; r.dpm = d; r.enm = m; r.lz = z;
    return r;
  endfunction

  // A digit shows if enabled and not a leading zero (digit 0 always may show)
  function automatic bit digit_shown(input disp_t s, input int d);
    bit upper_zero;
    upper_zero = 1'b1;
    if (!s.enm[d]) return 1'b0;
    for (int j = d; j < N; j++)
      if (((s.val >> (4 * j)) & 16'hF) != 16'h0) upper_zero = 1'b0;
    return !(s.lz && (d != 0) && upper_zero);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_t = 0; m_pend = 1'b0;
    m_shd = '0; m_stg = '0;
  endtask

  // Drive one clock of inputs and queue the pins expected after the next edge
  task automatic step(input logic e, input logic l, input disp_t d);
    pins_t x;
    int    pos, dig, nb;
    @(negedge clk);
    en = e; load = l; value = d.val; dp_in = d.dpm; dig_en = d.enm; lz_sup = d.lz;
    pos = m_t % TD;
    dig = (m_t / TD) % N;
    x.an = 4'hF; x.c = 7'h7F; x.dp = 1'b1; x.fd = 1'b0;
    if (e && m_act) begin
      x.fd = (pos == TD - 1) && (dig == N - 1);
      if (pos >= BC && digit_shown(m_shd, dig)) begin
        nb   = int'((m_shd.val >> (4 * dig)) & 16'hF);
        x.an = ~(4'b0001 << dig);
        x.c  = seg_tab[nb];
        x.dp = ~m_shd.dpm[dig];
      end
    end
    if (!m_act) begin
      if (l) m_shd = d;
      else if (m_pend) m_shd = m_stg;
      m_pend = 1'b0;
    end else if (x.fd) begin
      if (m_pend) m_shd = m_stg;
      m_pend = l;
    end else if (l) begin
      m_pend = 1'b1;
    end
    if (l) m_stg = d;
    if (!e) begin
      m_act = 1'b0; m_t = 0;
    end else if (!m_act) begin
      m_act = 1'b1; m_t = 0;
    end else begin
      m_t++;
    end
    exp_q.push_back(x);
    last_exp = x;
    if (l) $display("load value=%h dp=%b dig_en=%b lz=%b (en=%b)", d.val, d.dpm, d.enm, d.lz, e);
  endtask

  task automatic run(input int n, input disp_t d);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, d);
  endtask

  // Monitor: every cycle the DUT presents pins; compare with the oldest prediction
  initial begin
    pins_t x;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (frame_done === 1'b1) $display("frame_done at cycle %0d", cyc);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_total++;
        if ({an, c, dp, frame_done} === x) n_pass++;
        else $display("FAIL pins cyc=%0d: got an=%h c=%h dp=%b fd=%b want an=%h c=%h dp=%b fd=%b",
                      cyc, an, c, dp, frame_done, x.an, x.c, x.dp, x.fd);
      end
    end
  end

  initial begin
    disp_t d;
    n_pass = 0; n_total = 0;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst = 1'b0; en = 1'b0; load = 1'b0; value = '0; dp_in = '0; dig_en = '0; lz_sup = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_c", 32'(c), 32'h7F);
    chk("reset_dp", 32'(dp), 32'h1);
    chk("reset_fd", 32'(frame_done), 32'h0);
    rst = 1'b1;

    // Basic scan of 12AF with full masks
    d = mk(16'h12AF, 4'h0, 4'hF, 1'b0);
    step(1'b0, 1'b1, d);
    step(1'b0, 1'b0, d);
    run(70, d);

    // Tear-free: second load arrives mid-frame
    d = mk(16'h1111, 4'h0, 4'hF, 1'b0);
    step(1'b1, 1'b1, d);
    run(10, d);
    d = mk(16'h2222, 4'h0, 4'hF, 1'b0);
    step(1'b1, 1'b1, d);
    run(80, d);

    // Leading-zero blanking, including an all-zero value
    d = mk(16'h0050, 4'h0, 4'hF, 1'b1);
    step(1'b1, 1'b1, d);
    run(70, d);
    d = mk(16'h0000, 4'h0, 4'hF, 1'b1);
    step(1'b1, 1'b1, d);
    run(70, d);

    // Digit mask and decimal point
    d = mk(16'h12AF, 4'b0001, 4'b0101, 1'b0);
    step(1'b1, 1'b1, d);
    run(70, d);

    // Drop enable mid-slot, then restart
    d = mk(16'h9876, 4'b1010, 4'hF, 1'b0);
    step(1'b1, 1'b1, d);
    run(13, d);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, d);
    run(40, d);

    // Asynchronous reset while a digit is being driven
    for (int k = 0; k < TD * N; k++) begin
      if (m_act && (m_t % TD) > BC && (m_t % TD) < TD - 1) break;
      step(1'b1, 1'b0, d);
    end
    @(posedge clk);
    #3;
    chk("pre_reset_an", 32'(an), 32'(last_exp.an));
    rst = 1'b0;
    #1;
    chk("async_reset_an", 32'(an), 32'hF);
    chk("async_reset_c", 32'(c), 32'h7F);
    chk("async_reset_dp", 32'(dp), 32'h1);
    chk("async_reset_fd", 32'(frame_done), 32'h0);
    en = 1'b0; load = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // Shadow was cleared by reset: every digit is masked off
    run(40, d);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      logic e, l;
      e = ($urandom_range(0, 63) != 0);
      l = ($urandom_range(0, 19) == 0);
      if (l) begin
        d.val = 16'($urandom) >> (4 * $urandom_range(0, 4));
        d.dpm = 4'($urandom);
        d.enm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        d.lz  = 1'($urandom);
      end
      step(e, l, d);
    end

    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
